// File: rtl/btb_update_ctrl_pkg.sv
// BTB update-path types shared by btb_update_ctrl and btb_upd_fifo.
// Carries the rv32i_types additions: BTB geometry, update entry and scheduler states.
package btb_update_ctrl_pkg;
    localparam int BTB_DEPTH     = 32;
    localparam int IDXW          = $clog2(BTB_DEPTH);
    localparam int BTB_UPD_DEPTH = 4;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic [31:0]     pc;
    } btb_upd_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_DRAIN,
        S_HOLD
    } btb_upd_state_t;
endpackage

// File: rtl/btb_upd_fifo.sv
// In-order update queue: up to two enqueues and one pop per cycle.
// With BTB_UPD_COALESCE_EN defined, an enqueue hitting a live entry's idx rewrites its pc in place.
module btb_upd_fifo
    import btb_update_ctrl_pkg::*;
#(
    parameter int  DEPTH = BTB_UPD_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_pop,
    input  logic          i_acc0,
    input  logic          i_acc1,
    input  btb_upd_t      i_ent0,
    input  btb_upd_t      i_ent1,
    output btb_upd_t      o_head,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_count_nxt
);
    btb_upd_t      r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_push0;
    logic          w_push1;
    logic          w_ow0;
    logic          w_ow1;
    logic [PW-1:0] w_wa0;
    logic [PW-1:0] w_wa1;

`ifdef BTB_UPD_COALESCE_EN
    logic [DEPTH-1:0] w_live;
    logic             w_hit0;
    logic             w_hit1;
    logic             w_same;
    logic [PW-1:0]    w_loc0;
    logic [PW-1:0]    w_loc1;

    // The head that pops this cycle is not a merge target.
    for (genvar j = 0; j < DEPTH; j++) begin : g_live
        logic [PW-1:0] w_off;
        assign w_off     = PW'(j) - r_head;
        assign w_live[j] = ({1'b0, w_off} < r_count) && !(i_pop && (PW'(j) == r_head));
    end

    always_comb begin
        w_hit0 = 1'b0;
        w_hit1 = 1'b0;
        w_loc0 = '0;
        w_loc1 = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (w_live[j] && (r_mem[j].idx == i_ent0.idx)) begin
                w_hit0 = 1'b1;
                w_loc0 = PW'(j);
            end
            if (w_live[j] && (r_mem[j].idx == i_ent1.idx)) begin
                w_hit1 = 1'b1;
                w_loc1 = PW'(j);
            end
        end
    end

    assign w_same  = i_acc0 && i_acc1 && (i_ent0.idx == i_ent1.idx);
    assign w_push0 = i_acc0 && !w_hit0;
    assign w_push1 = i_acc1 && !w_hit1 && !w_same;
    assign w_ow0   = w_hit0;
    assign w_ow1   = w_hit1 || w_same;
    assign w_wa0   = w_hit0 ? w_loc0 : r_tail;
    assign w_wa1   = w_same ? w_wa0 : (w_hit1 ? w_loc1 : r_tail + PW'(w_push0));
`else
    assign w_push0 = i_acc0;
    assign w_push1 = i_acc1;
    assign w_ow0   = 1'b0;
    assign w_ow1   = 1'b0;
    assign w_wa0   = r_tail;
    assign w_wa1   = r_tail + PW'(w_push0);
`endif

    assign o_count_nxt = r_count + CW'(w_push0) + CW'(w_push1) - CW'(i_pop);
    assign o_count     = r_count;
    assign o_head      = (r_count != '0) ? r_mem[r_head] : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(i_pop);
            r_tail  <= r_tail + PW'(w_push0) + PW'(w_push1);
            r_count <= o_count_nxt;
        end
    end

    // req1 is written after req0 so it wins when both land on one slot.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (i_acc0) begin
                if (w_ow0) r_mem[w_wa0].pc <= i_ent0.pc;
                else       r_mem[w_wa0]    <= i_ent0;
            end
            if (i_acc1) begin
                if (w_ow1) r_mem[w_wa1].pc <= i_ent1.pc;
                else       r_mem[w_wa1]    <= i_ent1;
            end
        end
    end
endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port scheduler: arbitrates two resolve-side requesters into a queue, drains one write per cycle.
// Optional BTB_UPD_COALESCE_EN merges requests to an already-queued idx (handled in btb_upd_fifo).
//   state   | meaning
//   S_EMPTY | queue empty, write port idle
//   S_DRAIN | entries queued, one write per cycle
//   S_HOLD  | entries queued, write port held off by wr_hold
module btb_update_ctrl
    import btb_update_ctrl_pkg::*;
#(
    parameter int  UPD_DEPTH = BTB_UPD_DEPTH,
    localparam int CW        = $clog2(UPD_DEPTH) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [1:0]      i_req_valid,
    input  logic [IDXW-1:0] i_req_idx [2],
    input  logic [31:0]     i_req_pc  [2],
    output logic [1:0]      o_req_ready,
    input  logic            i_wr_hold,
    output logic            o_pc_next_misprediction,
    output logic [IDXW-1:0] o_btb_write_idx,
    output logic [31:0]     o_btb_write_pc,
    output logic [CW-1:0]   o_upd_count,
    output logic [15:0]     o_upd_drop_cnt
);
    btb_upd_state_t r_state;
    logic           r_rr_prio;
    logic [15:0]    r_drop_cnt;

    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_count_nxt;
    logic [CW-1:0]  w_free;
    logic [1:0]     w_acc;
    logic           w_pop;
    logic           w_contend;
    btb_upd_t       w_ent0;
    btb_upd_t       w_ent1;
    btb_upd_t       w_head;

    assign w_ent0 = '{idx: i_req_idx[0], pc: i_req_pc[0]};
    assign w_ent1 = '{idx: i_req_idx[1], pc: i_req_pc[1]};

    // Space is judged on registered count only; a same-cycle pop frees nothing.
    assign w_free = CW'(UPD_DEPTH) - w_count;

    always_comb begin
        o_req_ready = 2'b00;
        w_contend   = 1'b0;
        if (w_free >= CW'(2)) begin
            o_req_ready = 2'b11;
        end else if (w_free == CW'(1)) begin
            if (&i_req_valid) begin
                w_contend   = 1'b1;
                o_req_ready = r_rr_prio ? 2'b10 : 2'b01;
            end else begin
                o_req_ready = 2'b11;
            end
        end
    end

    assign w_acc = i_req_valid & o_req_ready;
    assign w_pop = (w_count != '0) && !i_wr_hold && i_rst_n;

    btb_upd_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_pop       (w_pop),
        .i_acc0      (w_acc[0]),
        .i_acc1      (w_acc[1]),
        .i_ent0      (w_ent0),
        .i_ent1      (w_ent1),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_count_nxt (w_count_nxt)
    );

    assign o_pc_next_misprediction = w_pop;
    assign o_btb_write_idx         = w_head.idx;
    assign o_btb_write_pc          = w_head.pc;
    assign o_upd_count             = w_count;
    assign o_upd_drop_cnt          = r_drop_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_EMPTY;
            r_rr_prio  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_contend) r_rr_prio <= ~r_rr_prio;
            if (|(i_req_valid & ~o_req_ready) && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
            case (r_state)
                S_EMPTY: if (|w_acc) r_state <= S_DRAIN;
                S_DRAIN: begin
                    if (w_count_nxt == '0) r_state <= S_EMPTY;
                    else if (i_wr_hold)    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (!i_wr_hold) r_state <= (w_count_nxt == '0) ? S_EMPTY : S_DRAIN;
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed vector bench for btb_update_ctrl; one record per clock cycle.
module tb_btb_update_ctrl;
    import btb_update_ctrl_pkg::*;

    localparam bit CO =
`ifdef BTB_UPD_COALESCE_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        logic            rst_n;
        logic [1:0]      vld;
        logic [IDXW-1:0] i0;
        logic [31:0]     p0;
        logic [IDXW-1:0] i1;
        logic [31:0]     p1;
        logic            hold;
        logic [1:0]      rdy;
        logic            we;
        logic [IDXW-1:0] idx;
        logic [31:0]     pc;
        logic [2:0]      cnt;
        logic [15:0]     drop;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [IDXW-1:0] req_idx [2];
    logic [31:0]     req_pc  [2];
    logic [1:0]      req_ready;
    logic            wr_hold;
    logic            we;
    logic [IDXW-1:0] wr_idx;
    logic [31:0]     wr_pc;
    logic [2:0]      upd_count;
    logic [15:0]     drop_cnt;

    int n_pass  = 0;
    int n_total = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    btb_update_ctrl dut (
        .i_clk                   (clk),
        .i_rst_n                 (rst_n),
        .i_req_valid             (req_valid),
        .i_req_idx               (req_idx),
        .i_req_pc                (req_pc),
        .o_req_ready             (req_ready),
        .i_wr_hold               (wr_hold),
        .o_pc_next_misprediction (we),
        .o_btb_write_idx         (wr_idx),
        .o_btb_write_pc          (wr_pc),
        .o_upd_count             (upd_count),
        .o_upd_drop_cnt          (drop_cnt)
    );

    function automatic vec_t mk(logic r, logic [1:0] vl, logic [IDXW-1:0] a0, logic [31:0] b0,
                                logic [IDXW-1:0] a1, logic [31:0] b1, logic h, logic [1:0] er,
                                logic ewe, logic [IDXW-1:0] ei, logic [31:0] ep, logic [2:0] ec,
                                logic [15:0] ed);
        vec_t v;
        v.rst_n = r;  v.vld = vl; v.i0 = a0; v.p0 = b0; v.i1 = a1; v.p1 = b1; v.hold = h;
        v.rdy = er;   v.we = ewe; v.idx = ei; v.pc = ep; v.cnt = ec; v.drop = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst_n      = v.rst_n;
        req_valid  = v.vld;
        req_idx[0] = v.i0;
        req_pc[0]  = v.p0;
        req_idx[1] = v.i1;
        req_pc[1]  = v.p1;
        wr_hold    = v.hold;
        #2;
        chk({tag, ".ready"}, 32'(req_ready), 32'(v.rdy));
        chk({tag, ".we"},    32'(we),        32'(v.we));
        chk({tag, ".idx"},   32'(wr_idx),    32'(v.idx));
        chk({tag, ".pc"},    wr_pc,          v.pc);
        chk({tag, ".count"}, 32'(upd_count), 32'(v.cnt));
        chk({tag, ".drop"},  32'(drop_cnt),  32'(v.drop));
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; wr_hold = 1'b0;
        req_idx[0] = '0; req_idx[1] = '0; req_pc[0] = '0; req_pc[1] = '0;
        repeat (2) @(posedge clk);

        //               rst vld  i0  p0            i1  p1      hld rdy   we  idx pc            cnt drop
        vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,      0, 2'b11, 0, 0,  0,            0, 0));
        vecs.push_back(mk(1, 2'b01, 5, 32'h60000010, 0, 0,      0, 2'b11, 0, 0,  0,            0, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b11, 1, 5,  32'h60000010, 1, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b11, 0, 0,  0,            0, 0));
        vecs.push_back(mk(1, 2'b11, 3, 32'h100,      7, 32'h200,0, 2'b11, 0, 0,  0,            0, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b11, 1, 3,  32'h100,      2, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b11, 1, 7,  32'h200,      1, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b11, 0, 0,  0,            0, 0));
        vecs.push_back(mk(1, 2'b11, 1, 32'h11,       2, 32'h22, 1, 2'b11, 0, 0,  0,            0, 0));
        vecs.push_back(mk(1, 2'b01, 3, 32'h33,       0, 0,      1, 2'b11, 0, 1,  32'h11,       2, 0));
        vecs.push_back(mk(1, 2'b11, 4, 32'h44,       5, 32'h55, 1, 2'b01, 0, 1,  32'h11,       3, 0));
        vecs.push_back(mk(1, 2'b11, 4, 32'h44,       5, 32'h55, 1, 2'b00, 0, 1,  32'h11,       4, 1));
        vecs.push_back(mk(1, 2'b11, 4, 32'h44,       5, 32'h55, 1, 2'b00, 0, 1,  32'h11,       4, 2));
        vecs.push_back(mk(1, 2'b11, 4, 32'h44,       5, 32'h55, 1, 2'b00, 0, 1,  32'h11,       4, 3));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b00, 1, 1,  32'h11,       4, 4));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b11, 1, 2,  32'h22,       3, 4));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b11, 1, 3,  32'h33,       2, 4));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b11, 1, 4,  32'h44,       1, 4));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b11, 0, 0,  0,            0, 4));
        vecs.push_back(mk(1, 2'b11, 6, 32'h66,       7, 32'h77, 1, 2'b11, 0, 0,  0,            0, 4));
        vecs.push_back(mk(1, 2'b11, 8, 32'h88,       9, 32'h99, 1, 2'b11, 0, 6,  32'h66,       2, 4));
        vecs.push_back(mk(1, 2'b01, 10,32'hAA,       0, 0,      0, 2'b00, 1, 6,  32'h66,       4, 4));
        vecs.push_back(mk(1, 2'b01, 10,32'hAA,       0, 0,      0, 2'b11, 1, 7,  32'h77,       3, 5));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b11, 1, 8,  32'h88,       3, 5));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b11, 1, 9,  32'h99,       2, 5));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b11, 1, 10, 32'hAA,       1, 5));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b11, 0, 0,  0,            0, 5));
        vecs.push_back(mk(1, 2'b11, 11,32'h0B,       12,32'h0C, 1, 2'b11, 0, 0,  0,            0, 5));
        vecs.push_back(mk(1, 2'b01, 13,32'h0D,       0, 0,      1, 2'b11, 0, 11, 32'h0B,       2, 5));
        vecs.push_back(mk(1, 2'b11, 14,32'h0E,       15,32'h0F, 1, 2'b10, 0, 11, 32'h0B,       3, 5));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b00, 1, 11, 32'h0B,       4, 6));
        vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,      0, 2'b11, 0, 12, 32'h0C,       3, 6));
        vecs.push_back(mk(1, 2'b00, 0, 0,            0, 0,      0, 2'b11, 0, 0,  0,            0, 0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

        // Merge into a queued idx: [9/A0, 2/B0] then 2/C0.
        apply(mk(1, 2'b11, 9, 32'hA0, 2, 32'hB0, 1, 2'b11, 0, 0, 0, 0, 0), "co1");
        apply(mk(1, 2'b01, 2, 32'hC0, 0, 0,      1, 2'b11, 0, 9, 32'hA0, 2, 0), "co2");
        apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b11, 1, 9, 32'hA0, CO ? 3'd2 : 3'd3, 0), "co3");
        apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b11, 1, 2, CO ? 32'hC0 : 32'hB0, CO ? 3'd1 : 3'd2, 0), "co4");
        apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b11, CO ? 1'b0 : 1'b1, CO ? 5'd0 : 5'd2,
                 CO ? 32'h0 : 32'hC0, CO ? 3'd0 : 3'd1, 0), "co5");
        apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0), "co6");

        // Same idx from both requesters in one cycle.
        apply(mk(1, 2'b11, 4, 32'h1, 4, 32'h2, 0, 2'b11, 0, 0, 0, 0, 0), "sm1");
        apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b11, 1, 4, CO ? 32'h2 : 32'h1, CO ? 3'd1 : 3'd2, 0), "sm2");
        apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b11, CO ? 1'b0 : 1'b1, CO ? 5'd0 : 5'd4,
                 CO ? 32'h0 : 32'h2, CO ? 3'd0 : 3'd1, 0), "sm3");
        apply(mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0), "sm4");

        // A request matching the head that pops this cycle takes a fresh slot.
        apply(mk(1, 2'b01, 6, 32'h70, 0, 0, 0, 2'b11, 0, 0, 0,       0, 0), "hd1");
        apply(mk(1, 2'b01, 6, 32'h77, 0, 0, 0, 2'b11, 1, 6, 32'h70,  1, 0), "hd2");
        apply(mk(1, 2'b00, 0, 0,      0, 0, 0, 2'b11, 1, 6, 32'h77,  1, 0), "hd3");
        apply(mk(1, 2'b00, 0, 0,      0, 0, 0, 2'b11, 0, 0, 0,       0, 0), "hd4");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
